// File: rtl/fp_normalize_pipe_if.sv
// Handshake and payload bundle for fp_normalize_pipe.
// slave = the normaliser, master = the upstream/downstream environment.
interface fp_normalize_pipe_if #(
  parameter int unsigned EXP_WIDTH   = 8,
  parameter int unsigned SIG_WIDTH   = 23,
  parameter int unsigned ADDER_WIDTH = SIG_WIDTH + 2
);
  logic                   in_valid;
  logic                   in_ready;
  logic [ADDER_WIDTH-1:0] add_sub_result;
  logic [EXP_WIDTH-1:0]   larger_exponent;
  logic [EXP_WIDTH-1:0]   exp_input_01;
  logic [EXP_WIDTH-1:0]   exp_input_02;
  logic [SIG_WIDTH-1:0]   significand_input_01;
  logic [SIG_WIDTH-1:0]   significand_input_02;
  logic                   is_factor_01_zero;
  logic                   is_factor_02_zero;
  logic                   is_add_sub_result_zero;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_WIDTH-1:0]   add_output_exponent;
  logic [SIG_WIDTH-1:0]   add_output_significands;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output in_valid, add_sub_result, larger_exponent, exp_input_01, exp_input_02,
           significand_input_01, significand_input_02, is_factor_01_zero,
           is_factor_02_zero, is_add_sub_result_zero, out_ready,
    input  in_ready, out_valid, add_output_exponent, add_output_significands,
           overflow, underflow
  );

  modport slave (
    input  in_valid, add_sub_result, larger_exponent, exp_input_01, exp_input_02,
           significand_input_01, significand_input_02, is_factor_01_zero,
           is_factor_02_zero, is_add_sub_result_zero, out_ready,
    output in_ready, out_valid, add_output_exponent, add_output_significands,
           overflow, underflow
  );
endinterface

// File: rtl/fp_normalize_pipe.sv
// Two-stage post-add/subtract normaliser with valid/ready flow control.
// Define FP_NORM_SATURATE_EN to saturate overflow to max finite instead of infinity.
module fp_normalize_pipe #(
  parameter int unsigned EXP_WIDTH   = 8,
  parameter int unsigned SIG_WIDTH   = 23,
  parameter int unsigned ADDER_WIDTH = SIG_WIDTH + 2
) (
  input logic                clk,
  input logic                rst_n,
  fp_normalize_pipe_if.slave bus
);
  localparam int unsigned LSH_WIDTH = $clog2(SIG_WIDTH + 1);
  localparam int unsigned IDX_WIDTH = $clog2(ADDER_WIDTH);
  localparam int unsigned EXT_WIDTH = EXP_WIDTH + 1;
  localparam logic [EXT_WIDTH-1:0] EXP_LIMIT = {1'b0, {EXP_WIDTH{1'b1}}};

  logic                   s1_adv_c, in_ready_c;
  logic [LSH_WIDTH-1:0]   lshift_c;

  logic                   s1_valid_q, s1_valid_d;
  logic [ADDER_WIDTH-1:0] sum_q, sum_d;
  logic [EXP_WIDTH-1:0]   lexp_q, lexp_d, exp1_q, exp1_d, exp2_q, exp2_d;
  logic [SIG_WIDTH-1:0]   sig1_q, sig1_d, sig2_q, sig2_d;
  logic                   z1_q, z1_d, z2_q, z2_d, zr_q, zr_d;
  logic [LSH_WIDTH-1:0]   lshift_q, lshift_d;

  logic                   s2_valid_q, s2_valid_d;
  logic [EXP_WIDTH-1:0]   out_exp_q, out_exp_d, res_exp_c;
  logic [SIG_WIDTH-1:0]   out_sig_q, out_sig_d, res_sig_c;
  logic                   ovf_q, ovf_d, res_ovf_c;
  logic                   unf_q, unf_d, res_unf_c;
  logic [EXT_WIDTH-1:0]   inc_exp_c;

  assign s1_adv_c   = !s2_valid_q || bus.out_ready;
  assign in_ready_c = !s1_valid_q || s1_adv_c;

  // Leading-one detect over the hidden-bit window; highest set bit wins.
  always_comb begin
    lshift_c = '0;
    for (int i = 0; i <= int'(SIG_WIDTH); i++) begin
      if (bus.add_sub_result[IDX_WIDTH'(i)]) lshift_c = LSH_WIDTH'(SIG_WIDTH - i);
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    sum_d      = sum_q;
    lexp_d     = lexp_q;
    exp1_d     = exp1_q;
    exp2_d     = exp2_q;
    sig1_d     = sig1_q;
    sig2_d     = sig2_q;
    z1_d       = z1_q;
    z2_d       = z2_q;
    zr_d       = zr_q;
    lshift_d   = lshift_q;
    if (in_ready_c) s1_valid_d = bus.in_valid;
    if (in_ready_c && bus.in_valid) begin
      sum_d    = bus.add_sub_result;
      lexp_d   = bus.larger_exponent;
      exp1_d   = bus.exp_input_01;
      exp2_d   = bus.exp_input_02;
      sig1_d   = bus.significand_input_01;
      sig2_d   = bus.significand_input_02;
      z1_d     = bus.is_factor_01_zero;
      z2_d     = bus.is_factor_02_zero;
      zr_d     = bus.is_add_sub_result_zero;
      lshift_d = lshift_c;
    end
  end

  // Stage-2 result selection, first matching case wins.
  always_comb begin
    res_exp_c = '0;
    res_sig_c = '0;
    res_ovf_c = 1'b0;
    res_unf_c = 1'b0;
    inc_exp_c = {1'b0, lexp_q} + EXT_WIDTH'(1);
    if (z1_q) begin
      res_exp_c = exp2_q;
      res_sig_c = sig2_q;
    end else if (z2_q) begin
      res_exp_c = exp1_q;
      res_sig_c = sig1_q;
    end else if (zr_q || (sum_q == '0)) begin
      res_exp_c = '0;
    end else if (sum_q[ADDER_WIDTH-1]) begin
      if (inc_exp_c >= EXP_LIMIT) begin
        res_ovf_c = 1'b1;
`ifdef FP_NORM_SATURATE_EN
        res_exp_c = {{(EXP_WIDTH-1){1'b1}}, 1'b0};
        res_sig_c = '1;
`else
        res_exp_c = '1;
        res_sig_c = '0;
`endif
      end else begin
        res_exp_c = inc_exp_c[EXP_WIDTH-1:0];
        res_sig_c = sum_q[ADDER_WIDTH-2:1];
      end
    end else if (EXT_WIDTH'(lshift_q) >= {1'b0, lexp_q}) begin
      res_unf_c = 1'b1;
    end else begin
      res_exp_c = EXP_WIDTH'({1'b0, lexp_q} - EXT_WIDTH'(lshift_q));
      res_sig_c = SIG_WIDTH'(sum_q << lshift_q);
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    out_exp_d  = out_exp_q;
    out_sig_d  = out_sig_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (s1_adv_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_exp_d = res_exp_c;
        out_sig_d = res_sig_c;
        ovf_d     = res_ovf_c;
        unf_d     = res_unf_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      sum_q      <= '0;
      lexp_q     <= '0;
      exp1_q     <= '0;
      exp2_q     <= '0;
      sig1_q     <= '0;
      sig2_q     <= '0;
      z1_q       <= 1'b0;
      z2_q       <= 1'b0;
      zr_q       <= 1'b0;
      lshift_q   <= '0;
      s2_valid_q <= 1'b0;
      out_exp_q  <= '0;
      out_sig_q  <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      sum_q      <= sum_d;
      lexp_q     <= lexp_d;
      exp1_q     <= exp1_d;
      exp2_q     <= exp2_d;
      sig1_q     <= sig1_d;
      sig2_q     <= sig2_d;
      z1_q       <= z1_d;
      z2_q       <= z2_d;
      zr_q       <= zr_d;
      lshift_q   <= lshift_d;
      s2_valid_q <= s2_valid_d;
      out_exp_q  <= out_exp_d;
      out_sig_q  <= out_sig_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign bus.in_ready                = in_ready_c;
  assign bus.out_valid               = s2_valid_q;
  assign bus.add_output_exponent     = out_exp_q;
  assign bus.add_output_significands = out_sig_q;
  assign bus.overflow                = ovf_q;
  assign bus.underflow               = unf_q;
endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Randomised scoreboard bench for fp_normalize_pipe (EXP_WIDTH=8, SIG_WIDTH=23).
module tb_fp_normalize_pipe;
  typedef struct packed {
    logic [24:0] sum;
    logic [7:0]  lexp, e1, e2;
    logic [22:0] s1, s2;
    logic        z1, z2, zr;
  } stim_t;

  typedef struct packed {
    logic [7:0]  exp;
    logic [22:0] sig;
    logic        ovf, unf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   acc_cnt = 0;
  int   ready_mode = 1;
  bit   sends_done;
  bit   hold_pending = 1'b0;
  logic [33:0] held;
  res_t sb[$];

  fp_normalize_pipe_if #(.EXP_WIDTH(8), .SIG_WIDTH(23), .ADDER_WIDTH(25)) bus ();

  fp_normalize_pipe #(.EXP_WIDTH(8), .SIG_WIDTH(23), .ADDER_WIDTH(25)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: normalise with plain integer arithmetic.
  function automatic res_t model(input stim_t s);
    res_t r;
    int   msb, sh, e;
    r = '0;
    if (s.z1) begin r.exp = s.e2; r.sig = s.s2; return r; end
    if (s.z2) begin r.exp = s.e1; r.sig = s.s1; return r; end
    if (s.zr || s.sum == 0) return r;
    if (s.sum >= 25'h1000000) begin
      e = int'(s.lexp) + 1;
      if (e >= 255) begin
        r.ovf = 1'b1;
`ifdef FP_NORM_SATURATE_EN
        r.exp = 8'd254;
        r.sig = 23'h7FFFFF;
`else
        r.exp = 8'd255;
`endif
      end else begin
        r.exp = 8'(e);
        r.sig = 23'(s.sum / 2);
      end
      return r;
    end
    msb = $clog2(int'(s.sum) + 1) - 1;
    sh  = 23 - msb;
    if (sh >= int'(s.lexp)) begin r.unf = 1'b1; return r; end
    r.exp = 8'(int'(s.lexp) - sh);
    r.sig = 23'(longint'(s.sum) * (longint'(1) << sh));
    return r;
  endfunction

  function automatic stim_t bus_stim();
    stim_t s;
    s.sum = bus.add_sub_result;      s.lexp = bus.larger_exponent;
    s.e1  = bus.exp_input_01;        s.e2   = bus.exp_input_02;
    s.s1  = bus.significand_input_01; s.s2  = bus.significand_input_02;
    s.z1  = bus.is_factor_01_zero;   s.z2   = bus.is_factor_02_zero;
    s.zr  = bus.is_add_sub_result_zero;
    return s;
  endfunction

  function automatic res_t cur_res();
    return {bus.add_output_exponent, bus.add_output_significands, bus.overflow, bus.underflow};
  endfunction

  function automatic stim_t mk(input logic [24:0] sum, input logic [7:0] lexp);
    stim_t s;
    s = '0;
    s.sum = sum; s.lexp = lexp;
    s.e1 = 8'($urandom); s.e2 = 8'($urandom);
    s.s1 = 23'($urandom); s.s2 = 23'($urandom);
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    logic [24:0] v;
    v = 25'($urandom);
    case ($urandom_range(3))
      0: v = v | 25'h1000000;
      1: v = (v & 25'hFFFFFF) >> $urandom_range(23);
      2: v = 25'($urandom_range(3));
      default: ;
    endcase
    case ($urandom_range(2))
      0: s = mk(v, 8'($urandom_range(24)));
      1: s = mk(v, 8'($urandom_range(255, 250)));
      default: s = mk(v, 8'($urandom));
    endcase
    s.z1 = ($urandom_range(15) == 0);
    s.z2 = ($urandom_range(15) == 0);
    s.zr = ($urandom_range(15) == 0);
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.add_sub_result = s.sum;       bus.larger_exponent = s.lexp;
    bus.exp_input_01 = s.e1;          bus.exp_input_02 = s.e2;
    bus.significand_input_01 = s.s1;  bus.significand_input_02 = s.s2;
    bus.is_factor_01_zero = s.z1;     bus.is_factor_02_zero = s.z2;
    bus.is_add_sub_result_zero = s.zr;
  endtask

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic send(input stim_t s);
    int n = 0;
    drive(s);
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 64'(n), 0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 0);
    @(posedge clk);
    #1;
  endtask

  // Downstream ready pattern, applied after the driver's edge-plus-one updates.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: bus.out_ready = 1'b0;
        1: bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(3) != 0);
      endcase
    end
  end

  // Monitor: handshakes are stable between the falling and the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) chk("stall_hold", 64'({bus.out_valid, cur_res()}), 64'(held));
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus_stim()));
        acc_cnt++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 1, 0);
        else chk("result", 64'(cur_res()), 64'(sb.pop_front()));
      end
      hold_pending = bus.out_valid && !bus.out_ready;
      held = {bus.out_valid, cur_res()};
    end
  end

  initial begin
    stim_t dir[$];
    int    a0, n;

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    drive('0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_in_ready", 64'(bus.in_ready), 1);
    chk("rst_outputs", 64'(cur_res()), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: one transfer, valid appears after the second edge.
    send(mk(25'h1000000, 8'd100));
    chk("lat_edge1", 64'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_edge2", 64'(bus.out_valid), 1);
    wait_drain();

    dir.push_back(mk(25'h0000001, 8'd100));
    dir.push_back(mk(25'h0C00000, 8'd100));
    dir.push_back(mk(25'h1800000, 8'd254));
    dir.push_back(mk(25'h1800000, 8'd253));
    dir.push_back(mk(25'h0000100, 8'd10));
    dir.push_back(mk(25'h0000100, 8'd15));
    dir.push_back(mk(25'h0000100, 8'd16));
    dir.push_back(mk(25'h0000000, 8'd50));
    dir.push_back(mk(25'h0123456, 8'd77));
    dir[$].zr = 1'b1;
    dir.push_back(mk(25'h1FFFFFF, 8'd1));
    dir[$].z1 = 1'b1; dir[$].zr = 1'b1;
    dir[$].e2 = 8'h80; dir[$].s2 = 23'h123456;
    dir.push_back(mk(25'h0ABCDEF, 8'd40));
    dir[$].z2 = 1'b1;
    foreach (dir[i]) send(dir[i]);
    wait_drain();

    // Stall: four offered, downstream blocked.
    ready_mode = 0;
    @(posedge clk);
    #1;
    a0 = acc_cnt;
    sends_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) send(rand_stim());
        sends_done = 1'b1;
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("stall_accepts", 64'(acc_cnt - a0), 2);
    chk("stall_in_ready", 64'(bus.in_ready), 0);
    chk("stall_out_valid", 64'(bus.out_valid), 1);
    ready_mode = 1;
    n = 0;
    while (!sends_done && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("stall_sends_done", 64'(sends_done), 1);
    #1;
    wait_drain();

    // Reset in the middle of a full-rate burst.
    for (int k = 0; k < 3; k++) begin
      drive(rand_stim());
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(bus.out_valid), 0);
    chk("rst_mid_in_ready", 64'(bus.in_ready), 1);
    bus.in_valid = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("no_stale_after_rst", 64'(bus.out_valid), 0);

    // Random traffic with random downstream back-pressure.
    ready_mode = 2;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1;
      end
      send(rand_stim());
    end
    ready_mode = 1;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
